// File: rtl/bus_cycle_sequencer.sv
// Splits CPU access requests into 68k bus cycles for the downstream bus FSM.
// Also assembles the read data it latches into one right-aligned 32-bit response.
module bus_cycle_sequencer #(
   parameter int ADDR_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_rw,
   input  logic [2:0]        req_fc,
   input  logic              fsm_waiting,
   input  logic              fsm_latch,
   input  logic              fsm_finalize,
   input  logic [15:0]       bus_rdata,
   output logic              activate,
   output logic              must_continue,
   output logic [ADDR_W-1:0] cyc_addr,
   output logic [15:0]       cyc_wdata,
   output logic              cyc_uds,
   output logic              cyc_lds,
   output logic              cyc_rw,
   output logic [2:0]        cyc_fc,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, RUN, RESPOND} state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_LONG = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   state_t      state, next_state;
   logic [1:0]  size_q;
   logic [15:0] wdata_lo;
   logic        beat;
   logic        req_bad;
   logic        long_beat0;

   // Reserved size, or a word/long access on an odd byte address.
   assign req_bad    = (req_size == SZ_RSVD) || ((req_size != SZ_BYTE) && req_addr[0]);
   assign long_beat0 = (size_q == SZ_LONG) && !beat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      // NOTE: every signal gets a default before the case, so no path can infer a latch.
      next_state = state;
      req_ready  = 1'b0;
      activate   = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) next_state = req_bad ? RESPOND : ISSUE;
         end
         ISSUE: begin
            activate = fsm_waiting;
            if (fsm_waiting) next_state = RUN;
         end
         // The beat-0 FINALIZE of a long access stays here: the FSM restarts on its own.
         RUN:     if (fsm_finalize && !long_beat0) next_state = RESPOND;
         RESPOND: if (resp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         size_q        <= SZ_BYTE;
         wdata_lo      <= '0;
         beat          <= 1'b0;
         must_continue <= 1'b0;
         cyc_addr      <= '0;
         cyc_wdata     <= '0;
         cyc_uds       <= 1'b0;
         cyc_lds       <= 1'b0;
         cyc_rw        <= 1'b1;
         cyc_fc        <= '0;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         resp_err      <= 1'b0;
      end else begin
         resp_valid <= (next_state == RESPOND);
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cyc_addr      <= req_addr;
                  cyc_rw        <= req_rw;
                  cyc_fc        <= req_fc;
                  size_q        <= req_size;
                  wdata_lo      <= req_wdata[15:0];
                  beat          <= 1'b0;
                  resp_rdata    <= '0;
                  resp_err      <= req_bad;
                  must_continue <= (req_size == SZ_LONG) && !req_bad;
                  case (req_size)
                     SZ_BYTE: begin
                        cyc_wdata <= {2{req_wdata[7:0]}};
                        cyc_uds   <= ~req_addr[0];
                        cyc_lds   <= req_addr[0];
                     end
                     SZ_LONG: begin
                        cyc_wdata <= req_wdata[31:16];
                        cyc_uds   <= 1'b1;
                        cyc_lds   <= 1'b1;
                     end
                     default: begin
                        cyc_wdata <= req_wdata[15:0];
                        cyc_uds   <= 1'b1;
                        cyc_lds   <= 1'b1;
                     end
                  endcase
               end
            end
            RUN: begin
               if (fsm_latch && cyc_rw) begin
                  if (size_q == SZ_BYTE)
                     resp_rdata[7:0] <= cyc_addr[0] ? bus_rdata[7:0] : bus_rdata[15:8];
                  else if (long_beat0)
                     resp_rdata[31:16] <= bus_rdata;
                  else
                     resp_rdata[15:0] <= bus_rdata;
               end
               // Beat-1 fields settle one cycle before the FSM re-enters SETUP_BUS.
               if (fsm_finalize && long_beat0) begin
                  beat          <= 1'b1;
                  cyc_addr      <= cyc_addr + ADDR_W'(2);
                  cyc_wdata     <= wdata_lo;
                  must_continue <= 1'b0;
               end
            end
            RESPOND: begin
               if (resp_ready) begin
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed self-checking bench for bus_cycle_sequencer; the bus FSM handshake is driven by hand.
module tb_bus_cycle_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [23:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        req_rw = 1'b1;
   logic [2:0]  req_fc = '0;
   logic        fsm_waiting = 1'b0;
   logic        fsm_latch = 1'b0;
   logic        fsm_finalize = 1'b0;
   logic [15:0] bus_rdata = '0;
   logic        activate;
   logic        must_continue;
   logic [23:0] cyc_addr;
   logic [15:0] cyc_wdata;
   logic        cyc_uds, cyc_lds, cyc_rw;
   logic [2:0]  cyc_fc;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int n_checks = 0;
   int n_fail   = 0;
   int act_cnt  = 0;
   bit resp_seen = 1'b0;
   int act_base;

   always #5 clk = ~clk;

   bus_cycle_sequencer #(.ADDR_W(24)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_size(req_size), .req_rw(req_rw), .req_fc(req_fc),
      .fsm_waiting(fsm_waiting), .fsm_latch(fsm_latch), .fsm_finalize(fsm_finalize),
      .bus_rdata(bus_rdata), .activate(activate), .must_continue(must_continue),
      .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata), .cyc_uds(cyc_uds), .cyc_lds(cyc_lds),
      .cyc_rw(cyc_rw), .cyc_fc(cyc_fc), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always @(posedge clk) begin
      if (activate)   act_cnt++;
      if (resp_valid) resp_seen = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic send_req(input logic [23:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input logic rw, input logic [2:0] fc);
      tick();
      req_addr = a; req_wdata = d; req_size = sz; req_rw = rw; req_fc = fc;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      settle();
   endtask

   task automatic grant();
      fsm_waiting = 1'b1;
      tick();
      fsm_waiting = 1'b0;
      settle();
   endtask

   task automatic latch_finalize(input logic [15:0] d);
      fsm_latch = 1'b1; bus_rdata = d;
      tick();
      fsm_latch = 1'b0; fsm_finalize = 1'b1;
      tick();
      fsm_finalize = 1'b0;
      settle();
   endtask

   task automatic respond();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      settle();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req_ready"},  32'(req_ready), 32'h1);
      check({tag, "_activate"},   32'(activate), 32'h0);
      check({tag, "_must_cont"},  32'(must_continue), 32'h0);
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
      check({tag, "_resp_err"},   32'(resp_err), 32'h0);
      check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
      check({tag, "_cyc_addr"},   32'(cyc_addr), 32'h0);
      check({tag, "_cyc_wdata"},  32'(cyc_wdata), 32'h0);
      check({tag, "_cyc_fc"},     32'(cyc_fc), 32'h0);
      check({tag, "_strobes"},    32'({cyc_uds, cyc_lds}), 32'h0);
      check({tag, "_cyc_rw"},     32'(cyc_rw), 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check_reset_values("rst");
      rst_n = 1'b1;

      // Word read at 0x000100.
      act_base = act_cnt;
      send_req(24'h000100, 32'h0, 2'd1, 1'b1, 3'd5);
      check("wr_req_ready_busy", 32'(req_ready), 32'h0);
      check("wr_addr", 32'(cyc_addr), 32'h000100);
      check("wr_fc", 32'(cyc_fc), 32'h5);
      check("wr_strobes", 32'({cyc_uds, cyc_lds}), 32'h3);
      check("wr_must_cont", 32'(must_continue), 32'h0);
      fsm_waiting = 1'b1; settle();
      check("wr_activate", 32'(activate), 32'h1);
      tick(); fsm_waiting = 1'b0; settle();
      check("wr_activate_off", 32'(activate), 32'h0);
      latch_finalize(16'hBEEF);
      check("wr_resp_valid", 32'(resp_valid), 32'h1);
      check("wr_rdata", resp_rdata, 32'h0000BEEF);
      check("wr_err", 32'(resp_err), 32'h0);
      check("wr_act_count", 32'(act_cnt - act_base), 32'h1);
      respond();
      check("wr_resp_drop", 32'(resp_valid), 32'h0);
      check("wr_ready_back", 32'(req_ready), 32'h1);

      // Long write wrapping at the top of the address space.
      act_base = act_cnt;
      send_req(24'hFFFFFE, 32'h12345678, 2'd2, 1'b0, 3'd1);
      check("lw_b0_addr", 32'(cyc_addr), 32'hFFFFFE);
      check("lw_b0_wdata", 32'(cyc_wdata), 32'h1234);
      check("lw_b0_must_cont", 32'(must_continue), 32'h1);
      check("lw_rw", 32'(cyc_rw), 32'h0);
      grant();
      check("lw_b0_must_cont_run", 32'(must_continue), 32'h1);
      latch_finalize(16'hFFFF);
      check("lw_b1_addr", 32'(cyc_addr), 32'h000000);
      check("lw_b1_wdata", 32'(cyc_wdata), 32'h5678);
      check("lw_b1_must_cont", 32'(must_continue), 32'h0);
      check("lw_b1_no_resp", 32'(resp_valid), 32'h0);
      latch_finalize(16'hFFFF);
      check("lw_resp_valid", 32'(resp_valid), 32'h1);
      check("lw_rdata", resp_rdata, 32'h0);
      check("lw_act_count", 32'(act_cnt - act_base), 32'h1);
      respond();

      // Byte reads at odd and even addresses.
      send_req(24'h000101, 32'h0, 2'd0, 1'b1, 3'd2);
      check("bo_strobes", 32'({cyc_uds, cyc_lds}), 32'h1);
      grant();
      latch_finalize(16'hAA55);
      check("bo_rdata", resp_rdata, 32'h00000055);
      respond();
      send_req(24'h000100, 32'h0, 2'd0, 1'b1, 3'd2);
      check("be_strobes", 32'({cyc_uds, cyc_lds}), 32'h2);
      grant();
      latch_finalize(16'hAA55);
      check("be_rdata", resp_rdata, 32'h000000AA);
      respond();

      // Byte write replicates the data byte on both lanes.
      send_req(24'h000201, 32'h000000C3, 2'd0, 1'b0, 3'd1);
      check("bw_wdata", 32'(cyc_wdata), 32'hC3C3);
      grant();
      latch_finalize(16'h1111);
      check("bw_rdata", resp_rdata, 32'h0);
      respond();

      // Misaligned word and reserved size are rejected without a bus cycle.
      act_base = act_cnt;
      fsm_waiting = 1'b1;
      send_req(24'h000103, 32'h0, 2'd1, 1'b1, 3'd1);
      check("ew_resp_valid", 32'(resp_valid), 32'h1);
      check("ew_err", 32'(resp_err), 32'h1);
      check("ew_activate", 32'(activate), 32'h0);
      respond();
      check("ew_err_clear", 32'(resp_err), 32'h0);
      send_req(24'h000100, 32'h0, 2'd3, 1'b1, 3'd1);
      check("es_resp_valid", 32'(resp_valid), 32'h1);
      check("es_err", 32'(resp_err), 32'h1);
      respond();
      fsm_waiting = 1'b0;
      check("err_act_count", 32'(act_cnt - act_base), 32'h0);

      // ACTIVATE waits for FSM_WAITING; response is held until RESP_READY.
      act_base = act_cnt;
      send_req(24'h000200, 32'h0, 2'd1, 1'b1, 3'd5);
      for (int i = 0; i < 5; i++) tick();
      check("wait_no_activate", 32'(act_cnt - act_base), 32'h0);
      grant();
      check("wait_act_count", 32'(act_cnt - act_base), 32'h1);
      latch_finalize(16'h1234);
      for (int i = 0; i < 4; i++) tick();
      check("hold_valid", 32'(resp_valid), 32'h1);
      check("hold_rdata", resp_rdata, 32'h00001234);
      check("hold_req_ready", 32'(req_ready), 32'h0);
      respond();

      // Reset between the beats of a long read.
      send_req(24'h000300, 32'h0, 2'd2, 1'b1, 3'd6);
      grant();
      latch_finalize(16'hDEAD);
      check("rm_b1_addr", 32'(cyc_addr), 32'h000302);
      rst_n = 1'b0; settle();
      resp_seen = 1'b0;
      check_reset_values("rm");
      tick();
      rst_n = 1'b1;
      fsm_latch = 1'b1; fsm_finalize = 1'b1; bus_rdata = 16'h5A5A;
      tick(); tick();
      fsm_latch = 1'b0; fsm_finalize = 1'b0;
      tick(); settle();
      check("rm_no_resp", 32'(resp_seen), 32'h0);
      check("rm_rdata_ignored", resp_rdata, 32'h0);
      send_req(24'h000400, 32'h0, 2'd2, 1'b1, 3'd6);
      grant();
      latch_finalize(16'hCAFE);
      check("rm_next_b1_addr", 32'(cyc_addr), 32'h000402);
      latch_finalize(16'hF00D);
      check("rm_next_rdata", resp_rdata, 32'hCAFEF00D);
      check("rm_next_err", 32'(resp_err), 32'h0);
      respond();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
